// File: rtl/bus_responder.sv
// bus_responder: target side of the CPU's multiplexed 8-bit bus.
// Collects a two-byte address over two handshake beats, then performs one
// read or write on a variable-latency backing-store port during the data beat
// and returns the read data (or absorbs the write data) over the same bus.
`timescale 1ns/1ps

module bus_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req_in,
    input  logic        bus_rd_in,
    input  logic        bus_wr_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic        bus_data_oe,
    output logic        bus_ack_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  beat,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        MEM      = 2'd1,
        ACK      = 2'd2
    } state_t;

    // Each stage holds {req, rd, wr}; index SYNC_STAGES-1 is the synchronised copy.
    logic [2:0]  sync_q [SYNC_STAGES];
    logic        rq;
    logic        rs;
    logic        ws;

    state_t      state_q;
    logic [1:0]  beat_q;
    logic [1:0]  beat_d;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        ack_q;
    logic        oe_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic        proto_err_q;

    // Synchroniser chain for the handshake and strobe inputs (data is bundled, not synchronised)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_q[0] <= {bus_req_in, bus_rd_in, bus_wr_in};
        end
    end

    assign rq = sync_q[SYNC_STAGES-1][2];
    assign rs = sync_q[SYNC_STAGES-1][1];
    assign ws = sync_q[SYNC_STAGES-1][0];

    // Beat counter advances 0 -> 1 -> 2 -> 0 at the end of each handshake
    assign beat_d = (beat_q == 2'd2) ? 2'd0 : beat_q + 2'd1;

    // Main handshake / backing-store FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_REQ;
            beat_q      <= 2'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            ack_q       <= 1'b0;
            oe_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_REQ: begin
                    if (rq) begin
                        case (beat_q)
                            2'd0: begin
                                addr_q[7:0] <= bus_data_in;
                                ack_q       <= 1'b1;
                                state_q     <= ACK;
                            end
                            2'd1: begin
                                addr_q[15:8] <= bus_data_in;
                                ack_q        <= 1'b1;
                                state_q      <= ACK;
                            end
                            2'd2: begin
                                if (rs ^ ws) begin
                                    if (ws) begin
                                        wdata_q <= bus_data_in;
                                    end
                                    mem_we_q  <= ws;
                                    mem_req_q <= 1'b1;
                                    state_q   <= MEM;
                                end else begin
                                    // Ambiguous or missing strobe: flag it, finish the
                                    // handshake so the initiator is not left hanging.
                                    proto_err_q <= 1'b1;
                                    ack_q       <= 1'b1;
                                    state_q     <= ACK;
                                end
                            end
                            default: begin
                                beat_q <= 2'd0;
                            end
                        endcase
                    end else if (!rs && !ws) begin
                        // Idle bus with no strobes: drop any partial address.
                        beat_q <= 2'd0;
                    end
                end

                MEM: begin
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        mem_req_q <= 1'b0;
                        ack_q     <= 1'b1;
                        oe_q      <= ~mem_we_q;
                        state_q   <= ACK;
                    end
                end

                ACK: begin
                    if (!rq) begin
                        ack_q   <= 1'b0;
                        oe_q    <= 1'b0;
                        beat_q  <= beat_d;
                        state_q <= WAIT_REQ;
                    end
                end

                default: begin
                    state_q <= WAIT_REQ;
                end
            endcase
        end
    end

    assign bus_data_out = rdata_q;
    assign bus_data_oe  = oe_q;
    assign bus_ack_out  = ack_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign beat         = beat_q;
    assign proto_err    = proto_err_q;

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- External-side target for the CPU's 8-bit multiplexed memory bus and 4-phase req/ack handshake.
- The CPU is the initiator. It drives `req` plus `rd`/`wr` strobes, then runs three beats per access: address low, address high, then data on a shared 8-bit bus.
- This block collects the address, runs one access on a variable-latency backing-store port, and returns read data or absorbs write data.
- Used in the FPGA/test harness in place of the off-chip memory controller.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on bus_req_in, bus_rd_in and bus_wr_in. Legal range is 1 or more.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_req_in  in  1  initiator request (CPU handshake out)
- bus_rd_in  in  1  initiator read strobe
- bus_wr_in  in  1  initiator write strobe
- bus_data_in  in  8  shared bus, as driven by the initiator
- bus_data_out  out  8  read data to the initiator
- bus_data_oe  out  1  output enable for bus_data_out
- bus_ack_out  out  1  acknowledge to the initiator (CPU handshake in)
- mem_req  out  1  backing-store request; held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  out  16  backing-store address
- mem_wdata  out  8  backing-store write data
- mem_rdata  in  8  backing-store read data; valid in the mem_ack cycle
- mem_ack  in  1  single-cycle completion pulse
- beat  out  2  current beat: 0 = address low, 1 = address high, 2 = data
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: all outputs 0; beat=0; state WAIT_REQ; address, write-data and read-data registers 0.
- Synchronisation:
  - req, rd and wr pass through SYNC_STAGES flops; rq, rs and ws below are the synchronised versions.
  - bus_data_in is bundled data and is not synchronised. It is sampled only when rq is 1; the initiator holds it stable from before req rises until it sees ack.
- State WAIT_REQ (bus_ack_out=0, bus_data_oe=0):
  - rq=1 and beat=0: addr[7:0] <= bus_data_in; go to ACK.
  - rq=1 and beat=1: addr[15:8] <= bus_data_in; go to ACK.
  - rq=1, beat=2, rs XOR ws = 1: if ws, wdata <= bus_data_in; go to MEM.
  - rq=1, beat=2, rs == ws (both 0 or both 1): proto_err <= 1; skip MEM; go to ACK; bus_data_oe stays 0 for this beat.
  - rq=0, rs=0 and ws=0: beat <= 0. This aborts any partial address and resyncs after an initiator reset.
- State MEM:
  - mem_req=1, mem_we=ws, mem_addr=addr, mem_wdata=wdata, all held stable until mem_ack.
  - On mem_ack: if read, rdata <= mem_rdata; mem_req <= 0 in the next cycle; go to ACK.
  - mem_ack outside MEM is ignored.
- State ACK:
  - bus_ack_out=1, registered; it rises on the first ACK cycle.
  - bus_data_oe=1 and bus_data_out=rdata only when beat=2 and the access is a read.
  - On rq=0: bus_ack_out <= 0 and bus_data_oe <= 0 in the same edge; beat <= (beat==2) ? 0 : beat+1; go to WAIT_REQ.
  - Read data therefore stays driven until after the initiator has dropped req; the initiator samples it one cycle after it observes ack.
- Handshake invariant:
  - ack never rises while rq=0.
  - ack never falls while rq=1.
  - One ack pulse per beat; three pulses per access.
- Back-to-back accesses: rd may stay high across accesses. beat wraps 2->0 and no idle cycle is required.
- Latency: a beat acks no earlier than SYNC_STAGES+1 cycles after req rises, plus the mem_ack latency on the data beat.
- Reset mid-operation (asynchronous): everything returns to its reset values immediately. mem_req drops even if an access is in flight; the backing store must tolerate an abandoned request.
- proto_err clears only on reset.

Test Plan:
- Read: mem[0x1234]=0xA5; initiator sends 0x34, then 0x12, with rd=1 -> mem_addr=0x1234, mem_we=0; bus_data_out=0xA5 with oe=1 while ack=1; three ack pulses.
- Write: wr=1, address 0xBEEF, data 0x5A; mem_ack delayed 7 cycles -> exactly one mem_req write to 0xBEEF with 0x5A; data-beat ack rises no earlier than the cycle after mem_ack.
- Back-to-back: rd held high through reads of 0x0000 and 0x0001 with no gap -> beat sequence 0,1,2,0,1,2; two mem reads; ack never asserted while rq=0.
- Abort: address-low beat, then rd=wr=0 for one cycle, then a new read of 0x00FF -> mem_addr=0x00FF, with no stale high byte.
- Protocol error: rd=wr=1 on the data beat -> proto_err=1, no mem_req, ack still completes; proto_err stays set through a subsequent good read.
- Reset: assert rst_n low in MEM state -> mem_req, bus_ack_out and bus_data_oe drop immediately; next access from beat 0 completes correctly.
